enoc_switch_allocator_rr: RTL

Per-output round-robin allocator with packet-level (wormhole) locking for the NxM one-hot crossbar switch of an ENoC router.
- Takes per-input output requests and tail flags from the input buffers, plus per-output ready from downstream flow control.
- Produces the crossbar's one-hot per-output select word and per-input dequeue grants.
- Sits between the input FIFOs and the crossbar in each router.

---
 rtl/enoc_switch_allocator_rr_pkg.sv | 19 +
 rtl/enoc_switch_allocator_rr_arbiter.sv | 33 +++
 rtl/enoc_switch_allocator_rr.sv | 121 ++++++++++++
 3 files changed

// File: rtl/enoc_switch_allocator_rr_pkg.sv
// Shared ENoC router configuration: default port counts, owner-encoding width
// and the per-output allocator state type.
package enoc_switch_allocator_rr_pkg;

  localparam int ENOC_N = 5;
  localparam int ENOC_M = 5;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ENOC_OWNER_W = owner_width(ENOC_N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_t;

endpackage

// File: rtl/enoc_switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one crossbar output: picks the first requester at or
// after the pointer (wrapping at N) and proposes the pointer past the winner.
module enoc_rr_arbiter
  import enoc_switch_allocator_rr_pkg::*;
#(
  parameter int N = ENOC_N,
  localparam int W = owner_width(N)
) (
  input  logic [0:N-1] req,
  input  logic [W-1:0] ptr,
  input  logic         ce,
  output logic [0:N-1] grant,
  output logic [W-1:0] next_ptr
);

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && ce && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = W'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/enoc_switch_allocator_rr.sv
// Per-output round-robin switch allocator with wormhole locking: an output stays
// owned by one input from the packet head until its tail flit transfers.
module enoc_switch_allocator_rr
  import enoc_switch_allocator_rr_pkg::*;
#(
  parameter int N = ENOC_N,
  parameter int M = ENOC_M
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [0:N-1][0:M-1]  i_req,
  input  logic [0:N-1]         i_tail,
  input  logic [0:M-1]         i_en,
  output logic [0:M-1][0:N-1]  o_sel,
  output logic [0:N-1]         o_grant,
  output logic [0:M-1]         o_lock
);

  localparam int W = owner_width(N);

  out_state_t          state    [M];
  logic [W-1:0]        owner    [M];
  logic [W-1:0]        ptr      [M];
  logic [W-1:0]        next_ptr [M];
  logic [W-1:0]        win_idx  [M];
  logic [0:N-1][0:M-1] req_eff;
  logic [0:M-1][0:N-1] col_req;
  logic [0:M-1][0:N-1] arb_grant;
  logic [0:M-1]        tail_xfer;

  // A row with several bits set keeps only its lowest-index output, so no
  // input can ever be granted on two outputs in the same cycle.
  always_comb begin
    logic taken;
    req_eff = '0;
    col_req = '0;
    for (int j = 0; j < N; j++) begin
      taken = 1'b0;
      for (int m = 0; m < M; m++) begin
        if (i_req[j][m] && !taken) begin
          req_eff[j][m] = 1'b1;
          taken         = 1'b1;
        end
      end
    end
    for (int m = 0; m < M; m++)
      for (int j = 0; j < N; j++)
        col_req[m][j] = req_eff[j][m];
  end

  for (genvar g = 0; g < M; g++) begin : g_arb
    enoc_rr_arbiter #(.N(N)) u_arb (
      .req      (col_req[g]),
      .ptr      (ptr[g]),
      .ce       (ce),
      .grant    (arb_grant[g]),
      .next_ptr (next_ptr[g])
    );
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      win_idx[m] = '0;
      for (int j = 0; j < N; j++)
        if (arb_grant[m][j]) win_idx[m] = W'(j);
    end
  end

  // Grants come from registered ownership plus live request/ready; reset forces them off.
  always_comb begin
    logic xfer;
    o_grant   = '0;
    tail_xfer = '0;
    o_sel     = '0;
    xfer      = 1'b0;
    for (int m = 0; m < M; m++) begin
      for (int j = 0; j < N; j++) begin
        xfer = (state[m] == LOCKED) && (owner[m] == W'(j)) && req_eff[j][m] &&
               i_en[m] && ce && reset_n;
        if (xfer) begin
          o_grant[j] = 1'b1;
          if (i_tail[j]) tail_xfer[m] = 1'b1;
        end
        if ((state[m] == LOCKED) && (owner[m] == W'(j))) o_sel[m][j] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++)
      o_lock[m] = (state[m] == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int m = 0; m < M; m++) begin
        state[m] <= IDLE;
        owner[m] <= '0;
        ptr[m]   <= '0;
      end
    end else if (ce) begin
      for (int m = 0; m < M; m++) begin
        case (state[m])
          IDLE: begin
            if (i_en[m] && (|col_req[m])) begin
              state[m] <= LOCKED;
              owner[m] <= win_idx[m];
              ptr[m]   <= next_ptr[m];
            end
          end
          LOCKED: begin
            if (tail_xfer[m]) state[m] <= IDLE;
          end
          default: state[m] <= IDLE;
        endcase
      end
    end
  end

endmodule
